// File: rtl/nubus_mstsched.sv
// Master-side request scheduler for the NuBus controller CPU port.
// Round-robin arbitration with lock hold, try-again retry and watchdog.
module nubus_mstsched #(
    parameter int NREQ      = 4,
    parameter int RETRY_MAX = 3,
    parameter int TMO_W     = 10
) (
    input  logic                nub_clk,
    input  logic                nub_reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*32-1:0]  req_addr,
    input  logic [NREQ*32-1:0]  req_wdata,
    input  logic [NREQ*4-1:0]   req_write,
    input  logic [NREQ-1:0]     req_lock,
    output logic [NREQ-1:0]     req_ready,
    output logic [31:0]         req_rdata,
    output logic [1:0]          req_err,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                cpu_valid,
    output logic [31:0]         cpu_addr,
    output logic [31:0]         cpu_wdata,
    output logic [3:0]          cpu_write,
    output logic                cpu_lock,
    output logic                cpu_eclr,
    input  logic                cpu_ready,
    input  logic [31:0]         cpu_rdata,
    input  logic [3:0]          cpu_errors
);

    localparam int PW = $clog2(NREQ);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, STATUS, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        write_q, write_d;
    logic              lock_q, lock_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic              cpu_lock_q, cpu_lock_d;
    logic              cpu_eclr_q, cpu_eclr_d;
    logic [TMO_W-1:0]  wdt_q, wdt_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              reissue_q, reissue_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [31:0]       req_rdata_q, req_rdata_d;
    logic [1:0]        req_err_q, req_err_d;

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic              done;
    logic [1:0]        done_err;
    logic [PW-1:0]     ptr_nxt;

    // Round-robin search upward from ptr, wrapping modulo NREQ
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!pick_found && req_valid[j]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(j);
            end
        end
    end

    assign ptr_nxt = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);

    // Transfer sequencing: next state, captured request and completion
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        lock_d      = lock_q;
        cpu_valid_d = cpu_valid_q;
        cpu_lock_d  = cpu_lock_q;
        cpu_eclr_d  = 1'b0;
        wdt_d       = wdt_q;
        retry_d     = retry_q;
        reissue_d   = reissue_q;
        rdata_d     = rdata_q;
        req_ready_d = '0;
        req_rdata_d = '0;
        req_err_d   = '0;
        done        = 1'b0;
        done_err    = 2'b00;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = ISSUE;
                    gidx_d      = pick_idx;
                    grant_d     = '0;
                    grant_d[pick_idx] = 1'b1;
                    addr_d      = req_addr[32*int'(pick_idx) +: 32];
                    wdata_d     = req_wdata[32*int'(pick_idx) +: 32];
                    write_d     = req_write[4*int'(pick_idx) +: 4];
                    lock_d      = req_lock[pick_idx];
                    cpu_valid_d = 1'b1;
                    cpu_lock_d  = req_lock[pick_idx];
                    wdt_d       = '0;
                    retry_d     = '0;
                    reissue_d   = 1'b0;
                end
            end
            ISSUE: begin
                wdt_d = wdt_q + TMO_W'(1);
                if (cpu_ready) begin
                    rdata_d     = cpu_rdata;
                    cpu_valid_d = 1'b0;
                    cpu_lock_d  = 1'b0;
                    state_d     = STATUS;
                end else if (&wdt_q) begin
                    cpu_valid_d = 1'b0;
                    cpu_lock_d  = 1'b0;
                    cpu_eclr_d  = 1'b1;
                    state_d     = CLEAR;
                    done        = 1'b1;
                    done_err    = 2'b01;
                end
            end
            STATUS: begin
                state_d    = CLEAR;
                cpu_eclr_d = 1'b1;
                if (cpu_errors == 4'b0000) begin
                    state_d    = IDLE;
                    cpu_eclr_d = 1'b0;
                    grant_d    = '0;
                    done       = 1'b1;
                end else if (cpu_errors[0]) begin
                    done     = 1'b1;
                    done_err = 2'b01;
                end else if (cpu_errors[2] && (retry_q < RW'(RETRY_MAX))) begin
                    retry_d   = retry_q + RW'(1);
                    reissue_d = 1'b1;
                end else if (cpu_errors[2]) begin
                    done     = 1'b1;
                    done_err = 2'b11;
                end else begin
                    done     = 1'b1;
                    done_err = 2'b10;
                end
            end
            CLEAR: begin
                if (reissue_q) begin
                    state_d     = ISSUE;
                    reissue_d   = 1'b0;
                    cpu_valid_d = 1'b1;
                    cpu_lock_d  = lock_q;
                    wdt_d       = '0;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            req_ready_d = grant_q;
            req_err_d   = done_err;
            req_rdata_d = (done_err == 2'b00) ? rdata_q : 32'h0;
            ptr_d       = lock_q ? gidx_q : ptr_nxt;
        end
    end

    // State and output registers
    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= '0;
            lock_q      <= 1'b0;
            cpu_valid_q <= 1'b0;
            cpu_lock_q  <= 1'b0;
            cpu_eclr_q  <= 1'b0;
            wdt_q       <= '0;
            retry_q     <= '0;
            reissue_q   <= 1'b0;
            rdata_q     <= '0;
            req_ready_q <= '0;
            req_rdata_q <= '0;
            req_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            lock_q      <= lock_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_lock_q  <= cpu_lock_d;
            cpu_eclr_q  <= cpu_eclr_d;
            wdt_q       <= wdt_d;
            retry_q     <= retry_d;
            reissue_q   <= reissue_d;
            rdata_q     <= rdata_d;
            req_ready_q <= req_ready_d;
            req_rdata_q <= req_rdata_d;
            req_err_q   <= req_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign req_rdata = req_rdata_q;
    assign req_err   = req_err_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign cpu_valid = cpu_valid_q;
    assign cpu_addr  = addr_q;
    assign cpu_wdata = wdata_q;
    assign cpu_write = write_q;
    assign cpu_lock  = cpu_lock_q;
    assign cpu_eclr  = cpu_eclr_q;

endmodule

// File: tb/tb_nubus_mstsched.sv
// Directed bench for nubus_mstsched: arbitration, retry, watchdog,
// lock hold, error status mapping and asynchronous reset.
module tb_nubus_mstsched;

    localparam int NREQ = 4;

    logic               clk;
    logic               nub_reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0]  req_write;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    req_ready;
    logic [31:0]        req_rdata;
    logic [1:0]         req_err;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               cpu_valid;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [3:0]         cpu_write;
    logic               cpu_lock;
    logic               cpu_eclr;
    logic               cpu_ready;
    logic [31:0]        cpu_rdata;
    logic [3:0]         cpu_errors;

    int checks = 0;
    int errors = 0;
    int cnt;

    nubus_mstsched #(.NREQ(4), .RETRY_MAX(3), .TMO_W(4)) dut (
        .nub_clk(clk), .nub_reset(nub_reset),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_write(req_write),
        .req_lock(req_lock), .req_ready(req_ready),
        .req_rdata(req_rdata), .req_err(req_err),
        .grant(grant), .busy(busy),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
        .cpu_lock(cpu_lock), .cpu_eclr(cpu_eclr),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_errors(cpu_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Returns cpu_ready after dly cycles of cpu_valid; leaves the bench
    // at the STATUS cycle with cpu_errors presented.
    task automatic respond(input int dly, input logic [31:0] rd,
                           input logic [3:0] er);
        repeat (dly - 1) tick();
        cpu_ready = 1'b1;
        cpu_rdata = rd;
        tick();
        cpu_ready  = 1'b0;
        cpu_errors = er;
    endtask

    function automatic logic [31:0] a_of(input int i);
        return 32'h4000_0000 + 32'(i) * 32'h100;
    endfunction

    initial begin
        nub_reset  = 1'b1;
        req_valid  = '0;
        req_wdata  = '0;
        req_write  = '0;
        req_lock   = '0;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        cpu_errors = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[32*i +: 32]  = a_of(i);
            req_wdata[32*i +: 32] = 32'hD000_0000 + 32'(i);
        end
        tick();
        tick();
        check("rst cpu_valid", cpu_valid, 0);
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst req_ready", req_ready, 0);
        check("rst cpu_eclr", cpu_eclr, 0);
        check("rst cpu_addr", cpu_addr, 0);
        nub_reset = 1'b0;

        // Round-robin over all four requesters
        req_valid = 4'b1111;
        tick();
        for (int r = 0; r < 5; r++) begin
            check("rr grant", grant, 4'b0001 << (r % 4));
            check("rr valid", cpu_valid, 1);
            check("rr addr", cpu_addr, a_of(r % 4));
            respond(3, 32'h5000_0000 + 32'(r), 4'b0000);
            check("rr status_valid", cpu_valid, 0);
            tick();
            check("rr ready", req_ready, 4'b0001 << (r % 4));
            check("rr err", req_err, 0);
            check("rr rdata", req_rdata, 32'h5000_0000 + 32'(r));
            check("rr grant_idle", grant, 0);
            if (r == 4) req_valid = '0;
            tick();
        end
        check("rr done_busy", busy, 0);

        // Try-again twice then success; requester drops valid once granted
        req_valid = 4'b0010;
        tick();
        check("ta grant", grant, 4'b0010);
        check("ta write", cpu_write, 0);
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            check("ta valid", cpu_valid, 1);
            check("ta addr", cpu_addr, a_of(1));
            respond(2, 32'hA0 + 32'(k), (k < 2) ? 4'b0100 : 4'b0000);
            tick();
            if (k < 2) begin
                check("ta eclr", cpu_eclr, 1);
                check("ta no_ready", req_ready, 0);
                cpu_errors = '0;
                tick();
            end else begin
                check("ta ready", req_ready, 4'b0010);
                check("ta err", req_err, 0);
                check("ta rdata", req_rdata, 32'hA2);
                check("ta no_eclr", cpu_eclr, 0);
            end
        end
        tick();

        // Retries exhausted on a write from requester 3
        req_valid = 4'b1000;
        req_write[15:12] = 4'hF;
        tick();
        check("rx grant", grant, 4'b1000);
        check("rx write", cpu_write, 4'hF);
        check("rx wdata", cpu_wdata, 32'hD000_0003);
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("rx valid", cpu_valid, 1);
            respond(1, 32'hBEEF, 4'b0100);
            tick();
            check("rx eclr", cpu_eclr, 1);
            if (k < 3) begin
                check("rx no_ready", req_ready, 0);
                cpu_errors = '0;
                tick();
            end else begin
                check("rx ready", req_ready, 4'b1000);
                check("rx err", req_err, 2'b11);
                check("rx rdata", req_rdata, 0);
                cpu_errors = '0;
            end
        end
        req_write = '0;
        tick();
        check("rx idle", busy, 0);

        // Watchdog: cpu_ready never returns
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        cnt = 0;
        while (cpu_valid === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("wd cycles", cnt, 16);
        check("wd eclr", cpu_eclr, 1);
        check("wd ready", req_ready, 4'b0001);
        check("wd err", req_err, 2'b01);
        check("wd rdata", req_rdata, 0);
        tick();

        // Lock hold: requester 2 keeps the grant over 0 and 3
        req_valid = 4'b1101;
        req_lock  = 4'b0100;
        tick();
        check("lk grant1", grant, 4'b0100);
        check("lk cpu_lock1", cpu_lock, 1);
        respond(1, 32'h11, 4'b0000);
        tick();
        check("lk ready1", req_ready, 4'b0100);
        req_lock = '0;
        tick();
        check("lk grant2", grant, 4'b0100);
        check("lk cpu_lock2", cpu_lock, 0);
        respond(1, 32'h22, 4'b0000);
        tick();
        check("lk ready2", req_ready, 4'b0100);
        req_valid = 4'b1001;
        tick();
        check("lk grant3", grant, 4'b1000);
        check("lk valid3", cpu_valid, 1);

        // Asynchronous reset in the middle of ISSUE
        #2 nub_reset = 1'b1;
        #1;
        check("ar cpu_valid", cpu_valid, 0);
        check("ar grant", grant, 0);
        check("ar busy", busy, 0);
        check("ar ready", req_ready, 0);
        check("ar eclr", cpu_eclr, 0);
        req_valid = 4'b0110;
        tick();
        nub_reset = 1'b0;
        tick();
        check("ar grant_after", grant, 4'b0010);
        check("ar valid_after", cpu_valid, 1);
        req_valid = '0;
        respond(1, 32'h77, 4'b0000);
        tick();
        check("ar ready_after", req_ready, 4'b0010);
        check("ar rdata_after", req_rdata, 32'h77);
        tick();

        // Bus error maps to status 10
        req_valid = 4'b0100;
        tick();
        check("be grant", grant, 4'b0100);
        req_valid = '0;
        respond(1, 32'h99, 4'b0010);
        tick();
        check("be eclr", cpu_eclr, 1);
        check("be ready", req_ready, 4'b0100);
        check("be err", req_err, 2'b10);
        check("be rdata", req_rdata, 0);
        cpu_errors = '0;
        tick();
        check("be idle", busy, 0);

        // Timeout bit wins over try-again
        req_valid = 4'b0001;
        tick();
        check("pr grant", grant, 4'b0001);
        req_valid = '0;
        respond(1, 32'h55, 4'b0101);
        tick();
        check("pr eclr", cpu_eclr, 1);
        check("pr err", req_err, 2'b01);
        cpu_errors = '0;
        tick();

        // cpu_ready on the watchdog terminal cycle is a completion
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (15) tick();
        check("tc valid16", cpu_valid, 1);
        cpu_ready = 1'b1;
        cpu_rdata = 32'h1234;
        tick();
        cpu_ready = 1'b0;
        check("tc status_valid", cpu_valid, 0);
        check("tc no_eclr", cpu_eclr, 0);
        tick();
        check("tc ready", req_ready, 4'b1000);
        check("tc err", req_err, 0);
        check("tc rdata", req_rdata, 32'h1234);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
